// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } t_md_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } t_md_state;

endpackage

// File: rtl/mips_muldiv_if.sv
// Core <-> multiply/divide unit connection: issue, MTHI/MTLO writes, stall and HI/LO readback.
interface mips_muldiv_if
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            clock_enable;
  logic            start;
  t_md_op          op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hi_write;
  logic            lo_write;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output clock_enable, start, op, op_a, op_b, hi_write, lo_write, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  clock_enable, start, op, op_a, op_b, hi_write, lo_write, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mips_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module mips_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // The extra top bit makes the borrow of the trial subtraction an exact sign bit.
  assign shifted = {rem_in, dvd_msb};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[XLEN+1];
  assign rem_out = q_bit ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: 32 RUN cycles plus one FIX/commit cycle.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  mips_muldiv_if.slave md
);

  t_md_state           state_reg;
  logic [MD_CNT_W-1:0] cnt_reg;
  t_md_op              op_reg;
  logic [XLEN-1:0]     a_reg;
  logic                sign_b_reg;
  logic [XLEN-1:0]     opnd_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN:0]       rem_reg;
  logic [XLEN-1:0]     hi_reg;
  logic [XLEN-1:0]     lo_reg;
  logic                done_reg;

  // Operand magnitudes; only the signed ops (op[0] == 0) fold negatives.
  logic            start_signed;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  assign start_signed = ~md.op[0];
  assign abs_a = (start_signed && md.op_a[XLEN-1]) ? -md.op_a : md.op_a;
  assign abs_b = (start_signed && md.op_b[XLEN-1]) ? -md.op_b : md.op_b;

  // Shift-add multiply: upper half accumulates, lower half shifts the multiplier out.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // Divide: acc_reg[XLEN-1:0] shifts dividend bits out and quotient bits in.
  logic [XLEN:0]     div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] div_next;

  mips_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_reg),
    .dvd_msb (acc_reg[XLEN-1]),
    .divisor (opnd_reg),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  assign div_next = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], div_q};

  logic              is_signed;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  assign is_signed = ~op_reg[0];
  assign neg_res   = is_signed & (a_reg[XLEN-1] ^ sign_b_reg);
  assign neg_rem   = is_signed & a_reg[XLEN-1];
  assign div_zero  = (opnd_reg == '0);
  assign prod_fix  = neg_res ? -acc_reg : acc_reg;
  assign quo_fix   = neg_res ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_fix   = neg_rem ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];

  // Divide by zero bypasses sign correction entirely.
  always_comb begin
    fix_hi = prod_fix[2*XLEN-1:XLEN];
    fix_lo = prod_fix[XLEN-1:0];
    if (op_reg[1]) begin
      if (div_zero) begin
        fix_hi = a_reg;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= MULT;
      a_reg      <= '0;
      sign_b_reg <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else if (md.clock_enable) begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (md.start) begin
            op_reg     <= md.op;
            a_reg      <= md.op_a;
            sign_b_reg <= md.op_b[XLEN-1];
            opnd_reg   <= md.op[1] ? abs_b : abs_a;
            acc_reg    <= {{XLEN{1'b0}}, (md.op[1] ? abs_a : abs_b)};
            rem_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end else begin
            if (md.hi_write) hi_reg <= md.wdata;
            if (md.lo_write) lo_reg <= md.wdata;
          end
        end
        RUN: begin
          acc_reg <= op_reg[1] ? div_next : mul_next;
          if (op_reg[1]) rem_reg <= div_rem;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == MD_CNT_W'(MD_ITER - 1)) state_reg <= FIX;
        end
        FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign md.busy = (state_reg != IDLE);
  assign md.done = done_reg;
  assign md.hi   = hi_reg;
  assign md.lo   = lo_reg;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed scoreboard bench for mips_muldiv_unit: latency, results, MTHI/MTLO, freeze and async reset.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_muldiv_if #(.XLEN(32)) md();

  mips_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int total  = 0;
  int passed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Independent reference built on the simulator's own signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa, sb, q, r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sa = a;
    sb = b;
    case (op)
      2'b00: return sa64 * sb64;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int freeze_at, input int exp_busy,
                        input logic wr_same);
    int n;
    logic [63:0] got;
    @(negedge clk);
    md.op       = t_md_op'(op);
    md.op_a     = a;
    md.op_b     = b;
    md.start    = 1'b1;
    md.lo_write = wr_same;
    md.wdata    = 32'hAAAA5555;
    exp_q.push_back(expv);
    @(negedge clk);
    md.start    = 1'b0;
    md.lo_write = 1'b0;
    n = 0;
    while (md.busy && n < 100) begin
      n++;
      if (n == 5) check("hold_hilo", {md.hi, md.lo}, {exp_hi, exp_lo});
      if (freeze_at > 0 && n == freeze_at) md.clock_enable = 1'b0;
      if (freeze_at > 0 && n == freeze_at + 5) md.clock_enable = 1'b1;
      @(negedge clk);
    end
    md.clock_enable = 1'b1;
    check("busy_cycles", 64'(n), 64'(exp_busy));
    check("done_pulse", 64'(md.done), 64'd1);
    got = exp_q.pop_front();
    check("hilo_result", {md.hi, md.lo}, got);
    $display("op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", op, a, b, n, md.hi, md.lo);
    exp_hi = got[63:32];
    exp_lo = got[31:0];
    @(negedge clk);
    check("done_clear", 64'(md.done), 64'd0);
  endtask

  initial begin
    int n;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    md.clock_enable = 1'b1;
    md.start    = 1'b0;
    md.op       = MULT;
    md.op_a     = '0;
    md.op_b     = '0;
    md.hi_write = 1'b0;
    md.lo_write = 1'b0;
    md.wdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(md.busy), 64'd0);
    check("rst_done", 64'(md.done), 64'd0);
    check("rst_hilo", {md.hi, md.lo}, 64'd0);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 0, 33, 1'b0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFF, 32'hFFFFFFEB}, 0, 33, 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 33, 1'b0);
    run_op(2'b11, 32'd7,        32'd0,        {32'h00000007, 32'hFFFFFFFF}, 0, 33, 1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 0, 33, 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 0, 33, 1'b0);

    // MTLO then MTHI in IDLE, each visible the cycle after its edge.
    md.lo_write = 1'b1;
    md.wdata    = 32'h00001234;
    @(negedge clk);
    md.lo_write = 1'b0;
    check("mtlo", {md.hi, md.lo}, {exp_hi, 32'h00001234});
    $display("mtlo wdata=%h hi=%h lo=%h", 32'h1234, md.hi, md.lo);
    md.hi_write = 1'b1;
    md.wdata    = 32'hCAFE0001;
    @(negedge clk);
    md.hi_write = 1'b0;
    check("mthi", {md.hi, md.lo}, {32'hCAFE0001, 32'h00001234});
    $display("mthi wdata=%h hi=%h lo=%h", 32'hCAFE0001, md.hi, md.lo);
    exp_hi = 32'hCAFE0001;
    exp_lo = 32'h00001234;

    // Start and MTLO together: start wins, write dropped.
    run_op(2'b00, 32'd2, 32'd3, {32'd0, 32'd6}, 0, 33, 1'b1);
    // Five frozen cycles mid-RUN stretch busy to 38.
    run_op(2'b01, 32'd5, 32'd6, {32'd0, 32'd30}, 10, 38, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'(i % 4);
      ra  = $urandom;
      rb  = (rop[1] && (i < 4)) ? $urandom_range(1, 100) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), 0, 33, 1'b0);
    end

    // Aborted operation: start/MTHI while busy ignored, then async reset at RUN cycle 10.
    @(negedge clk);
    md.op    = MULTU;
    md.op_a  = 32'd3;
    md.op_b  = 32'd4;
    md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    n = 0;
    while (md.busy && n < 100) begin
      n++;
      if (n == 3) begin
        md.start    = 1'b1;
        md.op       = DIVU;
        md.hi_write = 1'b1;
        md.wdata    = 32'h0000DEAD;
      end
      if (n == 4) begin
        md.start    = 1'b0;
        md.hi_write = 1'b0;
        check("ignore_hiwrite", {md.hi, md.lo}, {exp_hi, exp_lo});
      end
      if (n == 10) begin
        check("ignore_start_busy", 64'(md.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(md.busy), 64'd0);
        check("async_rst_hilo", {md.hi, md.lo}, 64'd0);
        $display("reset mid-run busy=%0d hi=%h lo=%h", md.busy, md.hi, md.lo);
        break;
      end
      @(negedge clk);
    end
    check("reached_reset", 64'(n), 64'd10);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    check("post_rst_idle", {62'd0, md.busy, md.done}, 64'd0);

    run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 33, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
